// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM encoding, transmitter bit-select
// constants and the default frame payload width.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    // Serializer phase select and the line levels it drives
    typedef enum logic [1:0] {
        BIT_START  = 2'd0,
        BIT_DATA   = 2'd1,
        BIT_PARITY = 2'd2,
        BIT_STOP   = 2'd3
    } uart_bitsel_e;

    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin search: first asserted request strictly after
// i_ptr, wrapping modulo NUM_REQ.
module uart_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [IDX_W-1:0] w_cand [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand[k] = IDX_W'((int'(i_ptr) + k + 1) % NUM_REQ);
        end
    end

    // Scan from the farthest candidate down so the nearest one wins
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// sources; issues a start pulse, tracks busy, enforces an idle gap.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 4,
    parameter int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                          UCLK,
    input  logic                          reset,
    input  logic                          tx_enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_busy,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          frame_done,
    output logic                          timeout_err,
    output logic [15:0]                   frame_count
);

    localparam int               TMR_W    = $clog2(BUSY_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES);

    logic [2:0]            r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic [IDX_W-1:0]      r_grant_id;
    logic                  r_frame_done;
    logic [15:0]           r_frame_count;
    logic [TMR_W-1:0]      r_timer;
    logic [7:0]            r_gap_cnt;

    logic                  w_pick_valid;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_grant;
    logic                  w_busy_fall;
    logic                  w_timeout;
    logic [2:0]            w_next_state;
    logic [NUM_REQ-1:0]    w_req_ready;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // The frame_done cycle itself is never grantable, so the next accept
    // lands GAP_CYCLES+1 cycles after the pulse.
    assign w_grant     = ~reset & (r_state == ST_IDLE) & ~r_frame_done &
                         tx_enable & ~tx_busy & w_pick_valid;
    assign w_busy_fall = (r_state == ST_WAIT_DONE) & ~tx_busy;
    assign w_timeout   = (r_state == ST_WAIT_BUSY) & ~tx_busy & (r_timer == TMR_LAST);

    always_comb begin
        w_req_ready = '0;
        if (w_grant) begin
            w_req_ready[w_pick_idx] = 1'b1;
        end
    end

    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:      w_next_state = w_grant ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:     w_next_state = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_next_state = ST_WAIT_DONE;
                end else if (r_timer == TMR_LAST) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_next_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT_DONE;
                end
            end
            ST_GAP:       w_next_state = (r_gap_cnt == GAP_LAST) ? ST_IDLE : ST_GAP;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= IDX_W'(NUM_REQ - 1);
            r_tx_data     <= '0;
            r_grant_id    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_timer       <= '0;
            r_gap_cnt     <= '0;
        end else begin
            r_state      <= w_next_state;
            r_frame_done <= w_busy_fall;
            if (w_grant) begin
                r_tx_data  <= req_data[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                r_grant_id <= w_pick_idx;
                r_ptr      <= w_pick_idx;
            end
            if (w_busy_fall) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            if (r_state == ST_ISSUE) begin
                r_timer <= '0;
            end else if ((r_state == ST_WAIT_BUSY) && !tx_busy && !w_timeout) begin
                r_timer <= r_timer + 1'b1;
            end
            if (r_state == ST_WAIT_DONE) begin
                r_gap_cnt <= '0;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end
        end
    end

    assign req_ready     = w_req_ready;
    assign tx_data_valid = (r_state == ST_ISSUE);
    assign tx_data       = r_tx_data;
    assign grant_id      = r_grant_id;
    assign frame_done    = r_frame_done;
    assign timeout_err   = w_timeout;
    assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a GAP_CYCLES=0 instance for the main
// sequences and a GAP_CYCLES=3 instance for the inter-frame gap.
module tb_uart_tx_arbiter;

    localparam int FRAME_LEN = 4;

    logic        UCLK      = 1'b0;
    logic        reset     = 1'b1;
    logic        tx_enable = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [15:0] req_data  = 16'h0000;
    logic [1:0]  req_ready;
    logic        tx_busy;
    logic        tx_data_valid;
    logic [7:0]  tx_data;
    logic [0:0]  grant_id;
    logic        frame_done;
    logic        timeout_err;
    logic [15:0] frame_count;

    logic [1:0]  g_req_valid = 2'b00;
    logic [15:0] g_req_data  = 16'h005A;
    logic [1:0]  g_req_ready;
    logic        g_tx_busy;
    logic        g_tx_data_valid;
    logic [7:0]  g_tx_data;
    logic [0:0]  g_grant_id;
    logic        g_frame_done;
    logic        g_timeout_err;
    logic [15:0] g_frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int tx_mode  = 0;

    logic m_busy   = 1'b0;
    int   m_cnt    = 0;
    logic g_m_busy = 1'b0;
    int   g_m_cnt  = 0;

    uart_tx_arbiter #(
        .NUM_REQ(2), .DATA_WIDTH(8), .GAP_CYCLES(0), .BUSY_TIMEOUT(4)
    ) dut (
        .UCLK(UCLK), .reset(reset), .tx_enable(tx_enable),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_busy(tx_busy), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
        .grant_id(grant_id), .frame_done(frame_done), .timeout_err(timeout_err),
        .frame_count(frame_count)
    );

    uart_tx_arbiter #(
        .NUM_REQ(2), .DATA_WIDTH(8), .GAP_CYCLES(3), .BUSY_TIMEOUT(4)
    ) dut_gap (
        .UCLK(UCLK), .reset(reset), .tx_enable(tx_enable),
        .req_valid(g_req_valid), .req_data(g_req_data), .req_ready(g_req_ready),
        .tx_busy(g_tx_busy), .tx_data_valid(g_tx_data_valid), .tx_data(g_tx_data),
        .grant_id(g_grant_id), .frame_done(g_frame_done), .timeout_err(g_timeout_err),
        .frame_count(g_frame_count)
    );

    always #5 UCLK = ~UCLK;

    // Nominal transmitter: busy rises the cycle after the start pulse and
    // stays high FRAME_LEN cycles; tx_mode=1 ignores the pulse entirely.
    always @(posedge UCLK) begin
        if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end else if (tx_data_valid && tx_mode == 0) begin
            m_busy <= 1'b1;
            m_cnt  <= FRAME_LEN - 1;
        end
    end

    always @(posedge UCLK) begin
        if (g_m_busy) begin
            if (g_m_cnt == 0) g_m_busy <= 1'b0;
            else              g_m_cnt  <= g_m_cnt - 1;
        end else if (g_tx_data_valid) begin
            g_m_busy <= 1'b1;
            g_m_cnt  <= FRAME_LEN - 1;
        end
    end

    assign tx_busy   = m_busy;
    assign g_tx_busy = g_m_busy;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge UCLK);
        #2;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 30) begin
            cyc();
            n++;
        end
        chk_eq("ready_seen", {31'b0, |req_ready}, 32'd1);
    endtask

    task automatic wait_done(input logic [7:0] exp_byte, output int n);
        int bad;
        n   = 0;
        bad = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            if (tx_data !== exp_byte) bad++;
            cyc();
            n++;
        end
        if (tx_data !== exp_byte) bad++;
        chk_eq("tx_data_hold", bad, 0);
        chk_eq("frame_done_seen", {31'b0, frame_done}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] exp_byte;
        int bad;

        // Reset state
        tx_enable = 1'b1;
        reset     = 1'b1;
        cyc();
        cyc();
        chk_eq("rst_req_ready",   32'(req_ready), 32'd0);
        chk_eq("rst_tx_valid",    32'(tx_data_valid), 32'd0);
        chk_eq("rst_tx_data",     32'(tx_data), 32'd0);
        chk_eq("rst_grant_id",    32'(grant_id), 32'd0);
        chk_eq("rst_frame_done",  32'(frame_done), 32'd0);
        chk_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk_eq("rst_frame_count", 32'(frame_count), 32'd0);
        reset = 1'b0;
        cyc();

        // Single request
        req_data  = 16'h00A5;
        req_valid = 2'b01;
        #1;
        chk_eq("single_ready", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 2'b00;
        #1;
        chk_eq("single_issue_valid", 32'(tx_data_valid), 32'd1);
        chk_eq("single_issue_data",  32'(tx_data), 32'hA5);
        chk_eq("single_ready_off",   32'(req_ready), 32'd0);
        cyc();
        chk_eq("single_valid_once",  32'(tx_data_valid), 32'd0);
        chk_eq("single_busy_rise",   32'(tx_busy), 32'd1);
        wait_done(8'hA5, n);
        chk_eq("single_done_latency", n, 32'd5);
        chk_eq("single_frame_count", 32'(frame_count), 32'd1);
        cyc();
        chk_eq("single_done_pulse", 32'(frame_done), 32'd0);

        // Contention: fresh pointer, both requesters valid throughout
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req_data  = 16'h2211;
        req_valid = 2'b11;
        for (int f = 0; f < 4; f++) begin
            exp_byte = (f % 2 == 0) ? 8'h11 : 8'h22;
            wait_ready(n);
            if (f > 0) chk_eq("rr_regrant_delay", n, 32'd1);
            chk_eq("rr_ready", 32'(req_ready), (f % 2 == 0) ? 32'd1 : 32'd2);
            cyc();
            chk_eq("rr_grant_id", 32'(grant_id), 32'(f % 2));
            chk_eq("rr_tx_data",  32'(tx_data), 32'(exp_byte));
            chk_eq("rr_tx_valid", 32'(tx_data_valid), 32'd1);
            wait_done(exp_byte, n);
        end
        req_valid = 2'b00;
        #1;
        chk_eq("rr_frame_count", 32'(frame_count), 32'd4);
        cyc();
        cyc();

        // Timeout: transmitter never goes busy
        tx_mode   = 1;
        req_valid = 2'b11;
        #1;
        chk_eq("to_ready", 32'(req_ready), 32'd1);
        cyc();
        chk_eq("to_issue_valid", 32'(tx_data_valid), 32'd1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        chk_eq("to_latency", n, 32'd4);
        chk_eq("to_frame_count", 32'(frame_count), 32'd4);
        tx_mode = 0;
        cyc();
        chk_eq("to_pulse_once", 32'(timeout_err), 32'd0);
        chk_eq("to_next_other", 32'(req_ready), 32'd2);
        cyc();
        req_valid = 2'b00;
        wait_done(8'h22, n);
        chk_eq("to_after_count", 32'(frame_count), 32'd5);

        // tx_enable dropped mid-frame with requests pending
        req_valid = 2'b11;
        wait_ready(n);
        chk_eq("en_ready", 32'(req_ready), 32'd1);
        cyc();
        cyc();
        cyc();
        tx_enable = 1'b0;
        wait_done(8'h11, n);
        chk_eq("en_frame_count", 32'(frame_count), 32'd6);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (req_ready !== 2'b00) bad++;
        end
        chk_eq("en_no_grant", bad, 0);
        tx_enable = 1'b1;
        #1;
        chk_eq("en_resume", 32'(req_ready), 32'd2);

        // Asynchronous reset in WAIT_DONE, transmitter still busy afterwards
        cyc();
        cyc();
        cyc();
        #3;
        reset = 1'b1;
        #1;
        chk_eq("ar_req_ready",   32'(req_ready), 32'd0);
        chk_eq("ar_tx_valid",    32'(tx_data_valid), 32'd0);
        chk_eq("ar_tx_data",     32'(tx_data), 32'd0);
        chk_eq("ar_grant_id",    32'(grant_id), 32'd0);
        chk_eq("ar_frame_done",  32'(frame_done), 32'd0);
        chk_eq("ar_timeout_err", 32'(timeout_err), 32'd0);
        chk_eq("ar_frame_count", 32'(frame_count), 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk_eq("ar_busy_blocks", 32'(req_ready), 32'd0);
        wait_ready(n);
        chk_eq("ar_wait_busy_fall", n, 32'd2);
        chk_eq("ar_first_winner", 32'(req_ready), 32'd1);
        cyc();
        req_valid = 2'b00;
        chk_eq("ar_grant_id_after", 32'(grant_id), 32'd0);
        chk_eq("ar_tx_data_after",  32'(tx_data), 32'h11);
        chk_eq("ar_count_after",    32'(frame_count), 32'd0);
        wait_done(8'h11, n);
        chk_eq("ar_count_done", 32'(frame_count), 32'd1);

        // Inter-frame gap on the GAP_CYCLES=3 instance
        g_req_valid = 2'b01;
        #1;
        chk_eq("gap_first_ready", 32'(g_req_ready), 32'd1);
        n = 0;
        while (g_frame_done !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk_eq("gap_done_seen", 32'(g_frame_done), 32'd1);
        chk_eq("gap_frame_count", 32'(g_frame_count), 32'd1);
        n = 0;
        while (g_req_ready == 2'b00 && n < 20) begin
            cyc();
            n++;
        end
        chk_eq("gap_idle_cycles", n, 32'd4);
        chk_eq("gap_regrant", 32'(g_req_ready), 32'd1);
        g_req_valid = 2'b00;
        cyc();
        chk_eq("gap_tx_data", 32'(g_tx_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
